// File: rtl/sweep_pkg.sv
// Shared types and pure helpers for the exhaustive sweep sequencer:
// FSM state encoding, binary-to-Gray conversion and one MISR step.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    EMIT,
    DONE
  } sweep_state_e;

  localparam int MAX_PAT_W = 32;
  localparam int MAX_SIG_W = 64;

  function automatic logic [MAX_PAT_W-1:0] gray_of(input logic [MAX_PAT_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Callers zero-extend into the wide operands and truncate the result back;
  // msb selects which bit of sig is the feedback tap for the real width.
  function automatic logic [MAX_SIG_W-1:0] misr_next(
    input logic [MAX_SIG_W-1:0] sig,
    input logic [MAX_SIG_W-1:0] poly,
    input logic [MAX_SIG_W-1:0] data,
    input logic [5:0]           msb
  );
    logic [MAX_SIG_W-1:0] shifted;
    shifted = sig << 1;
    if (sig[msb]) begin
      shifted = shifted ^ poly;
    end
    return shifted ^ data;
  endfunction

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: clear has priority over enable, and the
// signature only moves when enable is high.
module misr_reg
  import sweep_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [SIG_W-1:0] data_in,
  output logic [SIG_W-1:0] sig_out
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (enable) begin
      sig_d = SIG_W'(misr_next(MAX_SIG_W'(sig_q), MAX_SIG_W'(SIG_POLY),
                               MAX_SIG_W'(data_in), 6'(SIG_W - 1)));
    end
  end

  always_ff @(posedge clk) begin
    sig_q <= sig_d;
  end

  assign sig_out = sig_q;

endmodule

// File: rtl/exhaustive_sweep_sequencer.sv
// Walks every N_W-bit pattern into a DUT, captures each response after a hold
// window, hands (pattern, response) records to a logger and folds them into a MISR.
module exhaustive_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int               N_W      = 2,
  parameter int               OUT_W    = 1,
  parameter int               HOLD_CYC = 1,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             gray_mode,
  output logic [N_W-1:0]   N,
  input  logic [OUT_W-1:0] resp_in,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_W-1:0]   rec_pattern,
  output logic [OUT_W-1:0] rec_resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int               HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  // One spare count bit keeps the last-pattern test from aliasing at N_W=1.
  localparam logic [N_W:0]     CNT_LAST  = {1'b0, {N_W{1'b1}}};

  sweep_state_e     state_q, state_d;
  logic [N_W:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic             gray_q, gray_d;
  logic [N_W-1:0]   n_q, n_d;
  logic             rec_valid_q, rec_valid_d;
  logic [N_W-1:0]   rec_pattern_q, rec_pattern_d;
  logic [OUT_W-1:0] rec_resp_q, rec_resp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start_accept;
  logic             rec_fire;

  function automatic logic [N_W-1:0] pattern_of(input logic [N_W:0] c, input logic g);
    logic [N_W-1:0] p;
    if (g) begin
      p = N_W'(gray_of(MAX_PAT_W'(c)));
    end else begin
      p = c[N_W-1:0];
    end
    return p;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    gray_d        = gray_q;
    n_d           = n_q;
    rec_valid_d   = rec_valid_q;
    rec_pattern_d = rec_pattern_q;
    rec_resp_d    = rec_resp_q;
    busy_d        = busy_q;
    done_d        = done_q;
    start_accept  = 1'b0;
    rec_fire      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_accept = 1'b1;
          state_d      = APPLY;
          cnt_d        = '0;
          hold_d       = '0;
          gray_d       = gray_mode;
          n_d          = pattern_of('0, gray_mode);
          rec_valid_d  = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
        end
      end

      // The pattern has been on N since entry; sample only at the last hold clock
      // so a pipelined DUT has had time to settle.
      APPLY: begin
        if (hold_q == HOLD_LAST) begin
          hold_d        = '0;
          rec_resp_d    = resp_in;
          rec_pattern_d = n_q;
          rec_valid_d   = 1'b1;
          state_d       = EMIT;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      EMIT: begin
        if (rec_valid_q && rec_ready) begin
          rec_fire    = 1'b1;
          rec_valid_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + (N_W+1)'(1);
            n_d     = pattern_of(cnt_q + (N_W+1)'(1), gray_q);
            state_d = APPLY;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      gray_q        <= 1'b0;
      n_q           <= '0;
      rec_valid_q   <= 1'b0;
      rec_pattern_q <= '0;
      rec_resp_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      gray_q        <= gray_d;
      n_q           <= n_d;
      rec_valid_q   <= rec_valid_d;
      rec_pattern_q <= rec_pattern_d;
      rec_resp_q    <= rec_resp_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Signature restarts on every accepted start and advances once per accepted record.
  misr_reg #(
    .SIG_W    (SIG_W),
    .SIG_POLY (SIG_POLY)
  ) u_misr (
    .clk     (CK),
    .clear   (reset | start_accept),
    .enable  (rec_fire),
    .data_in (SIG_W'(rec_resp_q)),
    .sig_out (signature)
  );

  assign N           = n_q;
  assign rec_valid   = rec_valid_q;
  assign rec_pattern = rec_pattern_q;
  assign rec_resp    = rec_resp_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_exhaustive_sweep_sequencer.sv
// Scoreboard bench: instance A sweeps a combinational AND DUT with HOLD_CYC=1,
// instance B sweeps a registered XOR DUT with HOLD_CYC=3.
module tb_exhaustive_sweep_sequencer;

  typedef struct {
    logic [1:0] pattern;
    logic       resp;
  } rec_t;

  logic        clk;
  logic        reset;

  logic        start_a, gray_a, rec_ready_a;
  logic [1:0]  n_a, rec_pattern_a;
  logic        resp_a, rec_valid_a, rec_resp_a, busy_a, done_a;
  logic [15:0] sig_a;

  logic        start_b, gray_b, rec_ready_b;
  logic [1:0]  n_b, rec_pattern_b;
  logic        resp_b, rec_valid_b, rec_resp_b, busy_b, done_b;
  logic [15:0] sig_b;

  int          checks;
  int          failures;
  rec_t        exp_q_a[$];
  rec_t        exp_q_b[$];
  rec_t        pop_a, pop_b;
  logic [15:0] model_sig_a, model_sig_b;
  int          rec_cnt_a, rec_cnt_b;

  exhaustive_sweep_sequencer #(
    .N_W(2), .OUT_W(1), .HOLD_CYC(1), .SIG_W(16), .SIG_POLY(16'h1021)
  ) u_dut_a (
    .CK(clk), .reset(reset), .start(start_a), .gray_mode(gray_a), .N(n_a),
    .resp_in(resp_a), .rec_valid(rec_valid_a), .rec_ready(rec_ready_a),
    .rec_pattern(rec_pattern_a), .rec_resp(rec_resp_a), .busy(busy_a),
    .done(done_a), .signature(sig_a)
  );

  exhaustive_sweep_sequencer #(
    .N_W(2), .OUT_W(1), .HOLD_CYC(3), .SIG_W(16), .SIG_POLY(16'h1021)
  ) u_dut_b (
    .CK(clk), .reset(reset), .start(start_b), .gray_mode(gray_b), .N(n_b),
    .resp_in(resp_b), .rec_valid(rec_valid_b), .rec_ready(rec_ready_b),
    .rec_pattern(rec_pattern_b), .rec_resp(rec_resp_b), .busy(busy_b),
    .done(done_b), .signature(sig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT models: A is a combinational AND, B is an XOR with one clock of latency.
  assign resp_a = &n_a;
  always @(posedge clk) resp_b <= ^n_b;

  function automatic logic [15:0] model_misr(input logic [15:0] s, input logic r);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {15'b0, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records are retired at the negedge before the accepting posedge.
  always @(negedge clk) begin
    if (!reset && rec_valid_a && rec_ready_a) begin
      if (exp_q_a.size() == 0) begin
        checkOutput("a_record_expected", 32'(exp_q_a.size()), 32'd1);
      end else begin
        pop_a = exp_q_a.pop_front();
        checkOutput("a_rec_pattern", 32'(rec_pattern_a), 32'(pop_a.pattern));
        checkOutput("a_rec_resp", 32'(rec_resp_a), 32'(pop_a.resp));
        checkOutput("a_N_matches_rec", 32'(n_a), 32'(pop_a.pattern));
        model_sig_a = model_misr(model_sig_a, pop_a.resp);
        rec_cnt_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && rec_valid_b && rec_ready_b) begin
      if (exp_q_b.size() == 0) begin
        checkOutput("b_record_expected", 32'(exp_q_b.size()), 32'd1);
      end else begin
        pop_b = exp_q_b.pop_front();
        checkOutput("b_rec_pattern", 32'(rec_pattern_b), 32'(pop_b.pattern));
        checkOutput("b_rec_resp", 32'(rec_resp_b), 32'(pop_b.resp));
        model_sig_b = model_misr(model_sig_b, pop_b.resp);
        rec_cnt_b++;
      end
    end
  end

  task automatic pushSweepA(input logic gray);
    rec_t r;
    exp_q_a.delete();
    rec_cnt_a   = 0;
    model_sig_a = 16'h0;
    for (int i = 0; i < 4; i++) begin
      r.pattern = gray ? 2'(i ^ (i >> 1)) : 2'(i);
      r.resp    = &r.pattern;
      exp_q_a.push_back(r);
    end
  endtask

  // One full sweep on A; optional 5-clock ready stall in the 2nd EMIT and an
  // ignored start pulse mid-sweep.
  task automatic applyStimulus(input logic gray, input bit stall, input bit inject,
                               input logic [15:0] exp_sig);
    int         cycles;
    int         stalled;
    logic [1:0] last_pat;
    pushSweepA(gray);
    last_pat    = gray ? 2'b10 : 2'b11;
    rec_ready_a = 1'b1;
    gray_a      = gray;
    start_a     = 1'b1;
    tick();
    start_a = 1'b0;
    gray_a  = ~gray;
    cycles  = 1;
    stalled = 0;
    while (!done_a && cycles < 200) begin
      rec_ready_a = 1'b1;
      if (stall && rec_cnt_a == 1 && rec_valid_a && stalled < 5) begin
        rec_ready_a = 1'b0;
        checkOutput("a_stall_valid", 32'(rec_valid_a), 32'd1);
        checkOutput("a_stall_pattern", 32'(rec_pattern_a), 32'd1);
        checkOutput("a_stall_N", 32'(n_a), 32'd1);
        checkOutput("a_stall_sig", 32'(sig_a), 32'(model_sig_a));
        stalled++;
      end
      start_a = (inject && cycles == 3) ? 1'b1 : 1'b0;
      tick();
      cycles++;
    end
    start_a     = 1'b0;
    rec_ready_a = 1'b1;
    checkOutput("a_done", 32'(done_a), 32'd1);
    checkOutput("a_done_latency", 32'(cycles), 32'(stall ? 14 : 9));
    checkOutput("a_busy_at_done", 32'(busy_a), 32'd0);
    checkOutput("a_records", 32'(rec_cnt_a), 32'd4);
    checkOutput("a_queue_left", 32'(exp_q_a.size()), 32'd0);
    checkOutput("a_sig_model", 32'(sig_a), 32'(model_sig_a));
    checkOutput("a_sig_const", 32'(sig_a), 32'(exp_sig));
    tick();
    checkOutput("a_done_held", 32'(done_a), 32'd1);
    checkOutput("a_N_last", 32'(n_a), 32'(last_pat));
  endtask

  task automatic resetMidSweep();
    int cycles;
    pushSweepA(1'b0);
    rec_ready_a = 1'b1;
    gray_a      = 1'b0;
    start_a     = 1'b1;
    tick();
    start_a = 1'b0;
    cycles  = 0;
    while (!(n_a == 2'b10 && busy_a && !rec_valid_a) && cycles < 50) begin
      tick();
      cycles++;
    end
    checkOutput("rst_reach_apply10", 32'(n_a), 32'd2);
    reset = 1'b1;
    tick();
    checkOutput("rst_N", 32'(n_a), 32'd0);
    checkOutput("rst_rec_valid", 32'(rec_valid_a), 32'd0);
    checkOutput("rst_rec_pattern", 32'(rec_pattern_a), 32'd0);
    checkOutput("rst_rec_resp", 32'(rec_resp_a), 32'd0);
    checkOutput("rst_busy", 32'(busy_a), 32'd0);
    checkOutput("rst_done", 32'(done_a), 32'd0);
    checkOutput("rst_sig", 32'(sig_a), 32'd0);
    reset = 1'b0;
    exp_q_a.delete();
    tick();
    tick();
    checkOutput("rst_idle_busy", 32'(busy_a), 32'd0);
  endtask

  task automatic sweepB();
    int   cycles;
    rec_t r;
    exp_q_b.delete();
    rec_cnt_b   = 0;
    model_sig_b = 16'h0;
    for (int i = 0; i < 4; i++) begin
      r.pattern = 2'(i);
      r.resp    = ^r.pattern;
      exp_q_b.push_back(r);
    end
    rec_ready_b = 1'b1;
    gray_b      = 1'b0;
    start_b     = 1'b1;
    tick();
    start_b = 1'b0;
    cycles  = 1;
    while (!done_b && cycles < 200) begin
      tick();
      cycles++;
    end
    checkOutput("b_done", 32'(done_b), 32'd1);
    checkOutput("b_done_latency", 32'(cycles), 32'd17);
    checkOutput("b_records", 32'(rec_cnt_b), 32'd4);
    checkOutput("b_sig_model", 32'(sig_b), 32'(model_sig_b));
    checkOutput("b_sig_const", 32'(sig_b), 32'h0000_0006);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rec_cnt_a   = 0;
    rec_cnt_b   = 0;
    model_sig_a = 16'h0;
    model_sig_b = 16'h0;
    reset       = 1'b1;
    start_a     = 1'b1;
    gray_a      = 1'b0;
    rec_ready_a = 1'b1;
    start_b     = 1'b0;
    gray_b      = 1'b0;
    rec_ready_b = 1'b1;
    tick();
    tick();
    start_a = 1'b0;
    checkOutput("init_N", 32'(n_a), 32'd0);
    checkOutput("init_rec_valid", 32'(rec_valid_a), 32'd0);
    checkOutput("init_busy", 32'(busy_a), 32'd0);
    checkOutput("init_done", 32'(done_a), 32'd0);
    checkOutput("init_sig", 32'(sig_a), 32'd0);
    checkOutput("init_b_busy", 32'(busy_b), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("init_start_lost_in_reset", 32'(busy_a), 32'd0);

    $display("[TB] binary sweep, AND DUT");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0001);
    $display("[TB] gray sweep, AND DUT");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0002);
    $display("[TB] binary sweep with ready stall");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001);
    $display("[TB] binary sweep with mid-sweep start");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001);
    $display("[TB] repeat sweep from DONE");
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0001);
    $display("[TB] reset during APPLY of pattern 10");
    resetMidSweep();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0001);
    $display("[TB] HOLD_CYC=3 sweep, registered XOR DUT");
    sweepB();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
